regfile: RTL

- Architectural integer register file for the RV32I pipeline. It is the sink end of the writeback interface driven by the MEM/WB pipeline register.
- Accepts one write per cycle from WB.
- Serves two combinational read ports to ID (rs1/rs2) and one debug read port.
- x0 is hardwired to zero.

---
 rtl/regfile.sv | 76 +++++++
 1 files changed

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Brief    : RV32I integer register file. One WB write port, two gated
//            combinational ID read ports, and one debug read port. x0 reads
//            as zero. Defining REGFILE_BYPASS_EN forwards a same-cycle WB
//            write to a matching read port.
// Revision : 1.0 - initial release
// ============================================================================
module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  localparam logic [ADDR_W-1:0] c_x0 = '0;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [31:0]       r_wr_count;
  logic              w_wr_valid;
  logic [1:0]        w_re;
  logic [ADDR_W-1:0] w_raddr [2];

  // Entry 0 is only ever written by reset, so it stays zero.
  assign w_wr_valid = we && (waddr != c_x0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_wr_valid) begin
      r_regs[waddr] <= wdata;
      r_wr_count    <= r_wr_count + 32'd1;
    end
  end

  assign w_re       = {re2, re1};
  assign w_raddr[0] = raddr1;
  assign w_raddr[1] = raddr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic              w_hit;
    logic [DATA_W-1:0] w_data;
`ifdef REGFILE_BYPASS_EN
    assign w_hit = w_wr_valid && (w_raddr[p] == waddr);
`else
    assign w_hit = 1'b0;
`endif
    assign w_data = (rst || !w_re[p] || (w_raddr[p] == c_x0)) ? '0 :
                    w_hit ? wdata : r_regs[w_raddr[p]];
  end

  assign rdata1   = g_rd_port[0].w_data;
  assign rdata2   = g_rd_port[1].w_data;
  assign dbg_data = (dbg_addr == c_x0) ? '0 : r_regs[dbg_addr];
  assign wr_count = r_wr_count;

endmodule
`default_nettype wire
